// File: rtl/instr_flags_reg.sv
// Instruction register and C/Z/N/V flags register feeding the microcode sequencer.
// Opcode and flags are pure registers so the control-ROM address never glitches.
module instr_flags_reg #(
    parameter logic [7:0] RESET_OPCODE = 8'h00,
    parameter int          FLAG_BITS    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           bus_in,
    output logic [7:0]           bus_out,
    input  logic                 ir_loadn,
    input  logic                 fl_calcn,
    input  logic [FLAG_BITS-1:0] fl_mask,
    input  logic [FLAG_BITS-1:0] alu_flags,
    input  logic                 fl_busloadn,
    input  logic                 fl_outn,
    input  logic                 carry_set,
    input  logic                 carry_clr,
    output logic [7:0]           opcode,
    output logic [FLAG_BITS-1:0] flags,
    output logic                 ir_valid
);

    localparam int C_BIT = 0;

    logic [FLAG_BITS-1:0] flags_next;

    // Bus reload beats ALU update; the carry override then sits on top of the ALU result.
    always_comb begin
        flags_next = flags;
        if (!fl_busloadn) begin
            flags_next = bus_in[FLAG_BITS-1:0];
        end else begin
            if (!fl_calcn) begin
                for (int i = 0; i < FLAG_BITS; i++) begin
                    if (fl_mask[i]) begin
                        flags_next[i] = alu_flags[i];
                    end
                end
            end
            if (carry_set) begin
                flags_next[C_BIT] = 1'b1;
            end else if (carry_clr) begin
                flags_next[C_BIT] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opcode   <= RESET_OPCODE;
            ir_valid <= 1'b0;
            flags    <= '0;
        end else begin
            if (!ir_loadn) begin
                opcode   <= bus_in;
                ir_valid <= 1'b1;
            end
            flags <= flags_next;
        end
    end

    assign bus_out = fl_outn ? 8'bz : {{(8-FLAG_BITS){1'b0}}, flags};

endmodule

// File: tb/tb_instr_flags_reg.sv
// Self-checking bench for instr_flags_reg: directed scenarios plus randomized
// traffic compared against a behavioural model of opcode/flags/valid.
module tb_instr_flags_reg;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       ir_loadn, fl_calcn, fl_busloadn, fl_outn, carry_set, carry_clr;
    logic [3:0] fl_mask, alu_flags;
    logic [7:0] opcode;
    logic [3:0] flags;
    logic       ir_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_op;
    logic [3:0] m_fl;
    logic       m_valid;

    instr_flags_reg dut (
        .clk(clk), .rstn(rstn), .bus_in(bus_in), .bus_out(bus_out),
        .ir_loadn(ir_loadn), .fl_calcn(fl_calcn), .fl_mask(fl_mask),
        .alu_flags(alu_flags), .fl_busloadn(fl_busloadn), .fl_outn(fl_outn),
        .carry_set(carry_set), .carry_clr(carry_clr),
        .opcode(opcode), .flags(flags), .ir_valid(ir_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " opcode"}, opcode, m_op);
        checkOutput({tag, " flags"}, {4'b0, flags}, {4'b0, m_fl});
        checkOutput({tag, " ir_valid"}, {7'b0, ir_valid}, {7'b0, m_valid});
        checkOutput({tag, " bus_out"}, bus_out, fl_outn ? 8'bz : {4'b0, m_fl});
    endtask

    task automatic modelReset();
        m_op    = 8'h00;
        m_fl    = 4'b0000;
        m_valid = 1'b0;
    endtask

    // Reference behaviour: bus reload wins, else masked ALU merge then carry override.
    task automatic modelEdge();
        if (!ir_loadn) begin
            m_op    = bus_in;
            m_valid = 1'b1;
        end
        if (!fl_busloadn) begin
            m_fl = bus_in[3:0];
        end else begin
            if (!fl_calcn) m_fl = (m_fl & ~fl_mask) | (alu_flags & fl_mask);
            if (carry_set) m_fl[0] = 1'b1;
            else if (carry_clr) m_fl[0] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] b, input logic irl,
                                 input logic fcl, input logic [3:0] mask, input logic [3:0] alu,
                                 input logic fbl, input logic fo, input logic cs, input logic cc);
        @(negedge clk);
        bus_in = b; ir_loadn = irl; fl_calcn = fcl; fl_mask = mask; alu_flags = alu;
        fl_busloadn = fbl; fl_outn = fo; carry_set = cs; carry_clr = cc;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic randomInputs();
        bus_in      = 8'($urandom);
        ir_loadn    = 1'($urandom_range(0, 3) != 0);
        fl_calcn    = 1'($urandom);
        fl_mask     = 4'($urandom);
        alu_flags   = 4'($urandom);
        fl_busloadn = 1'($urandom_range(0, 3) != 0);
        fl_outn     = 1'($urandom);
        carry_set   = 1'($urandom_range(0, 4) == 0);
        carry_clr   = 1'($urandom_range(0, 4) == 0);
    endtask

    initial begin
        rstn = 1'b0;
        randomInputs();
        modelReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            randomInputs();
            fl_outn = 1'b1;
            #1;
            checkAll("reset");
        end
        @(negedge clk);
        rstn = 1'b1;

        applyStimulus("fetch", 8'hA5, 0, 1, 4'h0, 4'h0, 1, 1, 0, 0);
        applyStimulus("fetch_hold", 8'h3C, 1, 1, 4'h0, 4'h0, 1, 1, 0, 0);

        applyStimulus("calc_mask3", 8'h00, 1, 0, 4'b0011, 4'b1111, 1, 1, 0, 0);
        applyStimulus("calc_mask4", 8'h00, 1, 0, 4'b0100, 4'b0000, 1, 1, 0, 0);
        applyStimulus("calc_mask1", 8'h00, 1, 0, 4'b0001, 4'b0000, 1, 1, 0, 0);
        checkOutput("calc_literal", {4'b0, flags}, 8'h02);

        applyStimulus("prio_bus", 8'h09, 1, 0, 4'hF, 4'b0110, 0, 1, 0, 1);
        checkOutput("prio_bus_literal", {4'b0, flags}, 8'h09);
        applyStimulus("prio_carry", 8'h00, 1, 0, 4'hF, 4'b0000, 1, 1, 1, 1);
        checkOutput("prio_carry_literal", {4'b0, flags}, 8'h01);

        applyStimulus("save_load", 8'h0A, 1, 1, 4'h0, 4'h0, 0, 1, 0, 0);
        applyStimulus("save_drive", 8'h00, 1, 1, 4'h0, 4'h0, 1, 0, 0, 0);
        checkOutput("save_drive_literal", bus_out, 8'h0A);
        applyStimulus("save_float", 8'h00, 1, 1, 4'h0, 4'h0, 1, 1, 0, 0);
        applyStimulus("restore", 8'hF5, 1, 1, 4'h0, 4'h0, 0, 0, 0, 0);
        checkOutput("restore_literal", {4'b0, flags}, 8'h05);

        applyStimulus("pre_rst", 8'h7E, 0, 1, 4'h0, 4'h0, 1, 1, 1, 0);
        applyStimulus("pre_rst2", 8'h0F, 1, 1, 4'h0, 4'h0, 0, 1, 0, 0);
        @(negedge clk);
        ir_loadn = 1'b0; bus_in = 8'h11; fl_busloadn = 1'b1; fl_outn = 1'b1;
        carry_set = 1'b0; carry_clr = 1'b0; fl_calcn = 1'b1;
        #2 rstn = 1'b0;
        modelReset();
        #1;
        checkAll("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkAll("rst_release_pre");
        @(posedge clk);
        modelEdge();
        #1;
        checkAll("rst_release_post");
        checkOutput("rst_release_literal", opcode, 8'h11);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            randomInputs();
            if ($urandom_range(0, 39) == 0) begin
                #2 rstn = 1'b0;
                modelReset();
                #1;
                checkAll("rand_rst");
                #1 rstn = 1'b1;
            end
            @(posedge clk);
            modelEdge();
            #1;
            checkAll("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
